// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, bubble instruction and control-bundle bit positions
package pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
    localparam int CTRL_REG_DST    = 0;
    localparam int CTRL_ALU_OP_LO  = 1;
    localparam int CTRL_ALU_OP_HI  = 2;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_IS_BRANCH  = 7;
    localparam int CTRL_IS_JUMP    = 8;
    localparam int CTRL_SPARE      = 9;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: up-counter that sticks at all-ones
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count <= '0;
        else if (inc && count != '1) count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: two-entry IF/ID skid buffer with registered ready, flush and stall counter
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [CTRL_W-1:0] ctrl_o,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    logic [1:0] state, stateNext;
    logic [INST_W-1:0] mainInst, skidInst;
    logic [PC_W-1:0] mainPc, skidPc;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl;
    logic doAccept, doRelease, loadMain, loadSkid, promoteSkid;

    assign ready_o = state != ST_FULL;
    assign valid_o = state != ST_EMPTY;
    assign doAccept = valid_i && ready_o;
    assign doRelease = valid_o && ready_i;
    assign loadMain = doAccept && (state == ST_EMPTY || (state == ST_ONE && doRelease));
    assign loadSkid = doAccept && state == ST_ONE && !doRelease;
    assign promoteSkid = state == ST_FULL && doRelease;

    always_comb begin
        stateNext = flush_i ? ST_EMPTY :
                    state == ST_EMPTY ? (doAccept ? ST_ONE : ST_EMPTY) :
                    state == ST_ONE ? (loadSkid ? ST_FULL : (doRelease && !doAccept) ? ST_EMPTY : ST_ONE) :
                    doRelease ? ST_ONE : ST_FULL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_EMPTY;
            mainInst <= NOP_INST;
            mainPc   <= '0;
            mainCtrl <= '0;
            skidInst <= '0;
            skidPc   <= '0;
            skidCtrl <= '0;
        end else begin
            state <= stateNext;
            if (loadMain) begin
                mainInst <= inst_i;
                mainPc   <= pc_i;
                mainCtrl <= ctrl_i;
            end else if (promoteSkid) begin
                mainInst <= skidInst;
                mainPc   <= skidPc;
                mainCtrl <= skidCtrl;
            end
            if (loadSkid) begin
                skidInst <= inst_i;
                skidPc   <= pc_i;
                skidCtrl <= ctrl_i;
            end
        end
    end

    // bubbles carry a harmless NOP with all control bits clear
    assign inst_o = valid_o ? mainInst : NOP_INST;
    assign pc_o   = valid_o ? mainPc : '0;
    assign ctrl_o = valid_o ? mainCtrl : '0;

    pipe_sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc   (valid_o && !ready_i),
        .count (stall_cnt_o)
    );
endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb_if_id_skid_stage: directed table, corner sequences and randomized run against a queue model
module tb_if_id_skid_stage;
    logic clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, ready_i = 1'b0, flush_i = 1'b0;
    logic [31:0] inst_i = '0, pc_i = '0;
    logic [9:0] ctrl_i = '0;
    logic ready_o, valid_o, ready4, valid4;
    logic [31:0] inst_o, pc_o, inst4, pc4;
    logic [9:0] ctrl_o, ctrl4;
    logic [15:0] stall_cnt_o;
    logic [3:0] stall4;

    if_id_skid_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .inst_i(inst_i), .pc_i(pc_i), .ctrl_i(ctrl_i), .valid_o(valid_o),
        .ready_i(ready_i), .inst_o(inst_o), .pc_o(pc_o), .ctrl_o(ctrl_o),
        .flush_i(flush_i), .stall_cnt_o(stall_cnt_o)
    );

    if_id_skid_stage #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready4),
        .inst_i(inst_i), .pc_i(pc_i), .ctrl_i(ctrl_i), .valid_o(valid4),
        .ready_i(ready_i), .inst_o(inst4), .pc_o(pc4), .ctrl_o(ctrl4),
        .flush_i(flush_i), .stall_cnt_o(stall4)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [31:0] inst; logic [31:0] pc; logic [9:0] ctrl;} entryT;
    typedef struct {bit v; bit r; bit f; logic [31:0] inst; logic [31:0] pc;
                    bit expValid; bit expReady; logic [31:0] expInst; logic [31:0] expPc;} vecT;

    entryT q[$];
    int stallExp = 0, stall4Exp = 0;
    int errors = 0, checks = 0;
    vecT vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkModel(input string tag);
        logic [31:0] eInst, ePc;
        logic [9:0] eCtrl;
        eInst = '0; ePc = '0; eCtrl = '0;
        if (q.size() > 0) begin
            eInst = q[0].inst; ePc = q[0].pc; eCtrl = q[0].ctrl;
        end
        chk({tag, ".valid"}, 64'(valid_o), 64'(q.size() > 0));
        chk({tag, ".ready"}, 64'(ready_o), 64'(q.size() < 2));
        chk({tag, ".inst"}, 64'(inst_o), 64'(eInst));
        chk({tag, ".pc"}, 64'(pc_o), 64'(ePc));
        chk({tag, ".ctrl"}, 64'(ctrl_o), 64'(eCtrl));
        chk({tag, ".stall"}, 64'(stall_cnt_o), 64'(stallExp));
        chk({tag, ".stall4"}, 64'(stall4), 64'(stall4Exp));
    endtask

    task automatic modelEdge(input bit v, input bit r, input bit f,
                             input logic [31:0] inst, input logic [31:0] pc, input logic [9:0] ctrl);
        bit acc, rel;
        entryT e;
        acc = v && q.size() < 2;
        rel = q.size() > 0 && r;
        if (q.size() > 0 && !r) begin
            if (stallExp < 65535) stallExp++;
            if (stall4Exp < 15) stall4Exp++;
        end
        if (rel) void'(q.pop_front());
        e.inst = inst; e.pc = pc; e.ctrl = ctrl;
        if (acc) q.push_back(e);
        if (f) q.delete();
    endtask

    task automatic step(input bit v, input bit r, input bit f,
                        input logic [31:0] inst, input logic [31:0] pc, input logic [9:0] ctrl);
        valid_i = v; ready_i = r; flush_i = f; inst_i = inst; pc_i = pc; ctrl_i = ctrl;
        @(posedge clk_i);
        modelEdge(v, r, f, inst, pc, ctrl);
        @(negedge clk_i);
        chkModel("model");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int validCount;
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h2002_0005, 32'h4,  1'b1, 1'b1, 32'h2002_0005, 32'h4};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,  1'b0, 1'b1, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h1111_0001, 32'h10, 1'b1, 1'b1, 32'h1111_0001, 32'h10};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h1111_0002, 32'h14, 1'b1, 1'b0, 32'h1111_0001, 32'h10};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h1111_0003, 32'h18, 1'b1, 1'b0, 32'h1111_0001, 32'h10};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h1111_0003, 32'h18, 1'b1, 1'b1, 32'h1111_0002, 32'h14};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h1111_0003, 32'h18, 1'b1, 1'b1, 32'h1111_0003, 32'h18};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,  1'b0, 1'b1, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h2222_0001, 32'h30, 1'b1, 1'b1, 32'h2222_0001, 32'h30};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h2222_0002, 32'h34, 1'b1, 1'b0, 32'h2222_0001, 32'h30};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h2222_0003, 32'h38, 1'b0, 1'b1, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,  1'b0, 1'b1, 32'h0,         32'h0};

        #3;
        chk("reset.valid", 64'(valid_o), 64'(0));
        chk("reset.ready", 64'(ready_o), 64'(1));
        chk("reset.inst", 64'(inst_o), 64'(0));
        chk("reset.pc", 64'(pc_o), 64'(0));
        chk("reset.ctrl", 64'(ctrl_o), 64'(0));
        chk("reset.stall", 64'(stall_cnt_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].v, vecs[i].r, vecs[i].f, vecs[i].inst, vecs[i].pc, 10'(i + 1));
            chk($sformatf("vec%0d.valid", i), 64'(valid_o), 64'(vecs[i].expValid));
            chk($sformatf("vec%0d.ready", i), 64'(ready_o), 64'(vecs[i].expReady));
            chk($sformatf("vec%0d.inst", i), 64'(inst_o), 64'(vecs[i].expInst));
            chk($sformatf("vec%0d.pc", i), 64'(pc_o), 64'(vecs[i].expPc));
        end

        validCount = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i), 10'(i));
            chk($sformatf("stream%0d.ready", i), 64'(ready_o), 64'(1));
            chk($sformatf("stream%0d.pc", i), 64'(pc_o), 64'(32'h100 + 32'(4 * i)));
            if (valid_o) validCount++;
        end
        step(1'b0, 1'b1, 1'b0, '0, '0, '0);
        chk("stream.validCycles", 64'(validCount), 64'(8));

        step(1'b1, 1'b0, 1'b0, 32'h3333_0001, 32'h200, 10'h3FF);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("sat.stall4", 64'(stall4), 64'(4'hF));
        step(1'b0, 1'b1, 1'b0, '0, '0, '0);

        step(1'b1, 1'b0, 1'b0, 32'h4444_0001, 32'h300, 10'h155);
        step(1'b1, 1'b0, 1'b0, 32'h4444_0002, 32'h304, 10'h2AA);
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("asyncRst.valid", 64'(valid_o), 64'(0));
        chk("asyncRst.ready", 64'(ready_o), 64'(1));
        chk("asyncRst.inst", 64'(inst_o), 64'(0));
        chk("asyncRst.stall", 64'(stall_cnt_o), 64'(0));
        chk("asyncRst.stall4", 64'(stall4), 64'(0));
        q.delete();
        stallExp = 0;
        stall4Exp = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 1'b1, 1'b0, 32'h5555_0001, 32'h400, 10'h001);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                 $urandom, $urandom, 10'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_id_skid_stage.md
IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 SHALL have parameter INST_W, default 32, meaning instruction width.
REQ-002 SHALL have parameter PC_W, default 32, meaning program-counter width.
REQ-003 SHALL have parameter CTRL_W, default 10, meaning packed control-bundle width (RegDst, ALUOp[1:0], ALUSrc, RegWrite, MemToReg, MemWrite, IsBranch, IsJump, spare).
REQ-004 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 SHALL have parameter NOP_INST, default 32'h0000_0000, meaning instruction presented while the output is invalid.
REQ-006 clk_i  input  1  clock; all state changes on its rising edge.
REQ-007 rst_ni  input  1  asynchronous, active-low reset.
REQ-008 valid_i  input  1  upstream entry valid.
REQ-009 ready_o  output  1  stage can accept an entry this cycle.
REQ-010 inst_i / pc_i / ctrl_i  input  INST_W / PC_W / CTRL_W  upstream payload.
REQ-011 valid_o  output  1  downstream entry valid.
REQ-012 ready_i  input  1  downstream accepts this cycle.
REQ-013 inst_o / pc_o / ctrl_o  output  INST_W / PC_W / CTRL_W  head-entry payload.
REQ-014 flush_i  input  1  discard all held entries (branch/jump redirect).
REQ-015 stall_cnt_o  output  CNT_W  saturating count of downstream back-pressure cycles.

Function
REQ-016 SHALL hold at most two entries: main register (head) and skid register.
REQ-017 SHALL implement states EMPTY, ONE, FULL.
REQ-018 Accept = valid_i && ready_o; release = valid_o && ready_i.
REQ-019 ready_o SHALL be 1 in EMPTY and ONE, 0 in FULL, decoded from state register only (no combinational path from any input).
REQ-020 valid_o SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-021 EMPTY: accept -> ONE, payload into main; else stay.
REQ-022 ONE: accept without release -> FULL, payload into skid; release without accept -> EMPTY; accept with release -> ONE, payload into main; neither -> stay.
REQ-023 FULL: release -> ONE, skid moves into main; else stay with both registers unchanged.
REQ-024 Latency from accept in EMPTY to valid_o SHALL be exactly one cycle; throughput one entry per cycle while ready_i is held high.
REQ-025 Entries SHALL leave in acceptance order; none dropped or duplicated except by flush.
REQ-026 flush_i high SHALL force next state EMPTY, overriding any same-cycle accept or release; an entry accepted in that cycle is discarded.
REQ-027 While valid_o is 0: inst_o SHALL be NOP_INST, pc_o 0, ctrl_o 0 (bubble safe for downstream control).
REQ-028 stall_cnt_o SHALL increment by 1 each cycle with valid_o=1 and ready_i=0, saturate at all-ones, and not be cleared by flush_i.
REQ-029 Payload outputs SHALL come directly from the main register (no input-to-output combinational path).

Reset
REQ-030 While rst_ni=0, state SHALL be EMPTY immediately, independent of clk_i.
REQ-031 Reset values: valid_o 0, ready_o 1, inst_o NOP_INST, pc_o 0, ctrl_o 0, stall_cnt_o 0, skid register 0.
REQ-032 Reset asserted mid-operation SHALL discard both entries; the first accept after deassertion behaves as from EMPTY.

Structure
REQ-033 State encoding, NOP_INST default and control-bundle bit positions SHALL live in shared package pipe_pkg.
REQ-034 The saturating counter SHALL be a sub-module pipe_sat_counter (parameter CNT_W; inputs clk_i, rst_ni, inc; output count).

Verification
REQ-035 Reset then one accept of inst 32'h2002_0005, pc 32'h0000_0004, ready_i=1 -> valid_o=1 next cycle with those values, EMPTY the cycle after.
REQ-036 Stream of 8 entries, ready_i=1 throughout -> 8 consecutive valid_o cycles, in order, ready_o never 0.
REQ-037 ready_i=0 with 3 entries offered -> 2 accepted, ready_o=0 from third cycle, stall_cnt_o increments each stalled cycle; ready_i=1 -> entries 1,2 in order, third then accepted.
REQ-038 FULL plus flush_i=1 with valid_i=1 -> next cycle valid_o=0, inst_o=NOP_INST, ctrl_o=0, ready_o=1; offered entry lost.
REQ-039 CNT_W=4, 20 stalled cycles -> stall_cnt_o holds 4'hF.
REQ-040 rst_ni pulled low between clock edges while FULL -> valid_o=0 and ready_o=1 without a clock edge.
